// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer for an N x N output-stationary systolic MAC array
module systolic_ctrl #(
    parameter int N     = 4,
    parameter int KW    = 8,
    parameter int SKEW  = 2,
    parameter int DRAIN = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            stall,
    output logic            busy,
    output logic            pe_en,
    output logic            pe_rst_n,
    output logic [N-1:0]    lane_valid,
    output logic [N*KW-1:0] lane_addr,
    output logic            capture,
    output logic            done
);

    localparam int SPAN = SKEW * (N - 1);
    localparam int CW   = $clog2((1 << KW) + SPAN + 1);
    localparam int DW   = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   c, c_n;
    logic [DW-1:0]   d, d_n;
    logic [KW-1:0]   k_reg, k_n;
    logic [CW-1:0]   k_ext, c_last, lo;
    logic            feed_beat;
    logic            busy_n, pe_en_n, pe_rst_n_n, capture_n;
    logic [N-1:0]    valid_n;
    logic [N*KW-1:0] addr_n;

    assign k_ext  = {{(CW-KW){1'b0}}, k_reg};
    assign c_last = k_ext + CW'(SPAN) - CW'(1);

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        state_n    = state;
        c_n        = c;
        d_n        = d;
        k_n        = k_reg;
        feed_beat  = 1'b0;
        busy_n     = 1'b1;
        pe_en_n    = 1'b0;
        pe_rst_n_n = 1'b1;
        capture_n  = 1'b0;
        valid_n    = '0;
        addr_n     = '0;
        lo         = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    k_n        = k_len;
                    state_n    = S_CLEAR;
                    pe_rst_n_n = 1'b0;
                end else begin
                    busy_n = 1'b0;
                end
            end
            S_CLEAR: begin
                c_n = '0;
                d_n = '0;
                if (k_reg != '0) begin
                    state_n   = S_FEED;
                    pe_en_n   = 1'b1;
                    feed_beat = 1'b1;
                end else begin
                    state_n   = S_CAPTURE;
                    capture_n = 1'b1;
                end
            end
            S_FEED: begin
                // A stall inserts a bubble; the beat already presented is not re-sent.
                if (stall) begin
                    addr_n = lane_addr;
                end else if (c == c_last) begin
                    state_n = S_DRAIN;
                    d_n     = '0;
                    pe_en_n = 1'b1;
                end else begin
                    c_n       = c + CW'(1);
                    pe_en_n   = 1'b1;
                    feed_beat = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    if (d == DW'(DRAIN - 1)) begin
                        state_n   = S_CAPTURE;
                        capture_n = 1'b1;
                    end else begin
                        d_n     = d + DW'(1);
                        pe_en_n = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase

        for (int i = 0; i < N; i++) begin
            lo = CW'(SKEW * i);
            if (feed_beat && (c_n >= lo) && (c_n < lo + k_ext)) begin
                valid_n[i]             = 1'b1;
                addr_n[i*KW +: KW]     = KW'(c_n - lo);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            c          <= '0;
            d          <= '0;
            k_reg      <= '0;
            busy       <= 1'b0;
            pe_en      <= 1'b0;
            pe_rst_n   <= 1'b0;
            lane_valid <= '0;
            lane_addr  <= '0;
            capture    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            c          <= c_n;
            d          <= d_n;
            k_reg      <= k_n;
            busy       <= busy_n;
            pe_en      <= pe_en_n;
            pe_rst_n   <= pe_rst_n_n;
            lane_valid <= valid_n;
            lane_addr  <= addr_n;
            capture    <= capture_n;
            done       <= capture_n;
        end
    end

endmodule
